mem_responder: RTL
==================

# mem_responder

Memory-side responder for the pipelined CPU's two memory ports. Port 1 (instruction fetch) is a zero-wait combinational read. Port 2 (data) is a level-request / `ready_m2` handshake with a configurable fixed latency, driving the shared bidirectional `data2` bus on reads. The block sits in the testbench/top level opposite `datapath`, backed by a single word-addressed array.

## Interface
- `WORD_SIZE`, 16: data and address width in bits.
- `MEM_DEPTH`, 65536: number of words; must be a power of two.
- `LATENCY`, 4: port-2 service latency in cycles; must be ≥ 1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-high.
- `read_m1`  in  1  instruction read enable.
- `address1`  in  WORD_SIZE  instruction word address.
- `data1`  out  WORD_SIZE  instruction word.
- `read_m2`  in  1  data read request; level, held until `ready_m2`.
- `write_m2`  in  1  data write request; level, held until `ready_m2`.
- `address2`  in  WORD_SIZE  data word address.
- `data2`  inout  WORD_SIZE  write data from the CPU, or read data driven by this block.
- `ready_m2`  out  1  port-2 request complete; high for exactly one cycle.
- `proto_err`  out  1  sticky flag, set when `read_m2` and `write_m2` are both high.
- `rd_count`, `wr_count`, `stall_cycles`  out  16 each  statistics counters (see Configuration).

## Operation
- Addressing: index = address mod `MEM_DEPTH`, taken from the low `log2(MEM_DEPTH)` bits. Out-of-range addresses wrap silently.
- Port 1: `data1` = mem[address1] when `read_m1` = 1; otherwise `data1` = 0. Purely combinational, with no interaction with the port-2 FSM.
- Port-2 FSM:
  - Three states: IDLE, BUSY, DONE.
  - IDLE → BUSY on a clock edge where exactly one of `read_m2`/`write_m2` is high. That edge latches the address index and the op type, and loads the counter with `LATENCY`-1. When `LATENCY` = 1, IDLE → DONE directly.
  - BUSY: the counter decrements every edge. At the edge where the counter is 0 → DONE.
  - BUSY with the request dropped (both `read_m2` and `write_m2` low at an edge) → IDLE. This aborts the request: no write, no `ready_m2`.
  - DONE: `ready_m2` = 1 for this cycle.
    - Read: drive `data2` = mem[latched index].
    - Write: at the closing edge, commit the `data2` value sampled at that edge to mem[latched index], provided `write_m2` is still high.
    - DONE → IDLE unconditionally.
- `data2` is high-Z in every cycle except DONE-with-read.
- `address2` changes during BUSY or DONE are ignored; the latched index is used.
- IDLE always lasts at least one cycle. A back-to-back request is accepted at the edge closing that IDLE cycle.
- Both requests high in IDLE: not accepted, FSM stays in IDLE, `proto_err` set to 1 until reset.
- Reset (any time):
  - State → IDLE, counter → 0, `ready_m2` = 0, `data2` released, `proto_err` = 0, statistics counters = 0.
  - Array contents are preserved.
  - An in-flight write is dropped.

## Timing
- Request first high in cycle 0: accepted at the edge closing cycle 0; `ready_m2` is high throughout cycle `LATENCY`. The CPU therefore sees exactly `LATENCY` not-ready cycles.
- Read data is valid on `data2` for the whole DONE cycle and is sampled by the CPU at its closing edge.
- A write becomes visible to port 1 and port 2 from the cycle after DONE.
- Port-1 read of an address being written in the DONE cycle returns the old value.
- Reset values of all outputs are 0, except `data1` (combinational) and `data2` (Z).

## Configuration
- `MEM_STATS_EN` defined:
  - `rd_count` and `wr_count` increment on each DONE cycle of the matching type.
  - `stall_cycles` increments on each cycle in which (`read_m2` | `write_m2`) & !`ready_m2`.
  - All three are 16-bit, saturate at 16'hFFFF, and clear on reset.
- `MEM_STATS_EN` undefined: the counter logic is omitted and all three outputs are tied to 0. The ports remain present.

## Structure
- Shared header next to opcodes.v holds:
  - FSM state encoding: IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10.
  - The `MEM_STATS_EN` guard.
  - `WORD_SIZE`, taken from opcodes.v.
- One sub-module, `mem_latency_counter`:
  - Loadable down-counter with a `zero` output, async reset.
  - Counter width $clog2(`LATENCY`)+1.

## Test plan
- `LATENCY` = 4, read_m2 = 1, address2 = 16'h0010, mem[16] = 16'hBEEF → ready_m2 low in cycles 0–3, high only in cycle 4 with data2 = 16'hBEEF; data2 = Z in cycle 5.
- Write 16'h1234 to 16'h0020 with `LATENCY` = 2, then port-1 read of 16'h0020 → data1 = old value during DONE, 16'h1234 from the next cycle. With `MEM_STATS_EN`, wr_count = 1 and stall_cycles = 2.
- read_m2 dropped in the second BUSY cycle → no ready_m2 pulse; FSM in IDLE; the next request completes with normal latency.
- read_m2 and write_m2 both high in IDLE → proto_err = 1 and stays high; no ready_m2; memory unchanged.
- reset_n pulsed high mid-BUSY on a write → ready_m2 = 0 immediately; target word unchanged; counters = 0.
- address2 = 16'hFFFF with `MEM_DEPTH` = 256 → accesses word 255; `LATENCY` = 1 gives ready_m2 in cycle 1.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: port-2 FSM encoding, default word width,
// and helpers for the optional statistics block (enabled by defining MEM_STATS_EN).
package mem_responder_pkg;

    localparam int DEFAULT_WORD_SIZE = 16;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-facing memory port bundle: instruction fetch port and data-port handshake.
// The bidirectional data2 bus stays a direct port on the responder so tristate resolution lives at the top.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
);
    logic                 read_m1;
    logic [WORD_SIZE-1:0] address1;
    logic [WORD_SIZE-1:0] data1;
    logic                 read_m2;
    logic                 write_m2;
    logic [WORD_SIZE-1:0] address2;
    logic                 ready_m2;

    modport master (
        output read_m1, address1, read_m2, write_m2, address2,
        input  data1, ready_m2
    );

    modport slave (
        input  read_m1, address1, read_m2, write_m2, address2,
        output data1, ready_m2
    );
endinterface

// File: rtl/mem_responder_latency_counter.sv
// Loadable down-counter timing the data-port service latency.
// zero flags the cycle whose closing decrement brings the count to 0.
module mem_latency_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = dec && (count == WIDTH'(1));
endmodule

// File: rtl/mem_responder.sv
// Memory responder: combinational instruction port plus fixed-latency data port on a shared array.
// Build option: define MEM_STATS_EN to include the saturating read/write/stall counters.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int MEM_DEPTH = 65536,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_responder_if.slave       bus,
    inout  wire  [WORD_SIZE-1:0] data2,
    output logic                 proto_err,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count,
    output logic [15:0]          stall_cycles
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;

    logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

    logic [1:0]    state;
    op_t           op;
    logic [AW-1:0] idx;
    logic          req_any;
    logic          req_one;
    logic          cnt_load;
    logic          cnt_zero;
    logic          mem_we;

    assign req_any  = bus.read_m2 | bus.write_m2;
    assign req_one  = bus.read_m2 ^ bus.write_m2;
    assign cnt_load = (state == ST_IDLE) && req_one;

    mem_latency_counter #(.WIDTH(CW)) u_latency (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .load_value (CW'(LATENCY - 1)),
        .dec        (state == ST_BUSY),
        .zero       (cnt_zero)
    );

    // Dropping the request in BUSY takes priority over completion, so an abort never pulses ready.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state     <= ST_IDLE;
            op        <= OP_READ;
            idx       <= '0;
            proto_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_one) begin
                        op    <= bus.write_m2 ? OP_WRITE : OP_READ;
                        idx   <= bus.address2[AW-1:0];
                        state <= (LATENCY == 1) ? ST_DONE : ST_BUSY;
                    end else if (req_any) begin
                        proto_err <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!req_any) begin
                        state <= ST_IDLE;
                    end else if (cnt_zero) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_we = (state == ST_DONE) && (op == OP_WRITE) && bus.write_m2;

    // NOTE: the storage array is deliberately left out of reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= data2;
        end
    end

    assign bus.data1    = bus.read_m1 ? mem[bus.address1[AW-1:0]] : '0;
    assign bus.ready_m2 = (state == ST_DONE);
    assign data2        = ((state == ST_DONE) && (op == OP_READ)) ? mem[idx] : 'z;

`ifdef MEM_STATS_EN
    logic [15:0] rd_q;
    logic [15:0] wr_q;
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            stall_q <= '0;
        end else begin
            if ((state == ST_DONE) && (op == OP_READ)) rd_q <= sat_inc(rd_q);
            if ((state == ST_DONE) && (op == OP_WRITE)) wr_q <= sat_inc(wr_q);
            if (req_any && (state != ST_DONE)) stall_q <= sat_inc(stall_q);
        end
    end

    assign rd_count     = rd_q;
    assign wr_count     = wr_q;
    assign stall_cycles = stall_q;
`else
    assign rd_count     = '0;
    assign wr_count     = '0;
    assign stall_cycles = '0;
`endif

endmodule
